cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Miss/refill controller for the 4-set direct-mapped data cache (16-byte lines, 4 words per line). It sits between the CPU memory stage, the cache array and main data memory. On a load hit it completes the access with no stall. On a load miss it stalls the CPU, fetches the line word-by-word from memory, then issues a one-cycle line fill. Stores are write-through, no-allocate; a store that hits invalidates the line.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 32, byte address width
WORDS_PER_LINE, 4, words per cache line; must be a power of 2 and at least 2

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active low
cpu_req  in  1  CPU access request; held high until cpu_stall is low
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_WIDTH  byte address of the access
cpu_wdata  in  DATA_WIDTH  store data
cpu_byte  in  1  byte-wide access
cpu_stall  out  1  stalls the pipeline while the controller is busy
cpu_rdata  out  DATA_WIDTH  load data, passed through from cache_rdata
cache_hit  in  1  combinational hit from the cache array
cache_rdata  in  DATA_WIDTH  combinational read data from the cache array
cache_addr  out  ADDR_WIDTH  lookup, fill or invalidate address for the cache
cache_fill  out  1  one-cycle write of the refill line into the cache
cache_inv  out  1  one-cycle clear of the valid bit for the set at cache_addr
cache_line  out  WORDS_PER_LINE*DATA_WIDTH  refill line; word 0 in the LSBs
mem_req  out  1  memory request; held until mem_gnt
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  memory byte address
mem_wdata  out  DATA_WIDTH  memory write data
mem_byte  out  1  byte-wide memory write
mem_gnt  in  1  memory accepts the request in this cycle
mem_rvalid  in  1  read data valid; arrives at least 1 cycle after mem_gnt
mem_rdata  in  DATA_WIDTH  memory read data
hit_count  out  32  load-hit counter (optional feature only)
miss_count  out  32  load-miss counter (optional feature only)

Behaviour:
- Reset values (asynchronous, while rst_n = 0): state IDLE; word counter 0; line buffer 0; all outputs 0.
- States: IDLE, REFILL_REQ, REFILL_WAIT, FILL, STORE.
- IDLE:
  - cache_addr = cpu_addr.
  - Load hit (cpu_req & ~cpu_we & cache_hit): cpu_stall = 0 and cpu_rdata = cache_rdata in the same cycle; state stays IDLE.
  - Load miss: cpu_stall = 1 combinationally. Latch the line base (cpu_addr with offset bits cleared) and clear the counter. Next state is REFILL_REQ.
  - Store: cpu_stall = 1. Latch address, data and byte flag. If cache_hit, pulse cache_inv in this cycle. Next state is STORE.
- REFILL_REQ:
  - mem_req = 1, mem_we = 0, mem_addr = base + 4*cnt.
  - On mem_gnt, go to REFILL_WAIT.
- REFILL_WAIT:
  - On mem_rvalid, capture mem_rdata into word[cnt].
  - If cnt = WORDS_PER_LINE-1, go to FILL; otherwise increment cnt and return to REFILL_REQ.
  - mem_rvalid outside REFILL_WAIT is ignored.
- FILL:
  - cache_fill = 1 for exactly one cycle, with cache_addr = base and cache_line = the buffered words.
  - Next state is IDLE.
  - The CPU's held request re-looks up in IDLE and now hits. A load miss therefore costs 2 + sum of the memory latencies stall cycles.
- STORE:
  - mem_req = 1, mem_we = 1, mem_addr/mem_wdata/mem_byte from the latched values.
  - On mem_gnt, cpu_stall = 0 in that cycle and the next state is IDLE.
- cpu_stall = 1 in every state other than IDLE.
- mem_req is held with stable address and data until mem_gnt.
- The line buffer address wraps modulo the line size. The refill order is always word 0..N-1.
- Reset mid-refill: all state is discarded, no cache_fill is issued, and no partial line is written.
- cpu_byte does not affect refill; byte loads use the full line.

Optional Feature:
CACHE_STATS_EN.
- Defined:
  - hit_count increments on each IDLE load hit.
  - miss_count increments on each load miss detected in IDLE; the post-fill re-lookup counts as a hit.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Undefined: hit_count and miss_count are tied to 0 and no counter flops are built.

Decomposition:
- cache_pkg holds:
  - the state enum typedef (ctrl_state_t);
  - the constants OFFSET_BITS = $clog2(WORDS_PER_LINE) + 2 and LINE_BITS = WORDS_PER_LINE*DATA_WIDTH;
  - a line_base function that masks the offset bits.
- One sub-module, cache_stats_ctr (a saturating event counter), is instantiated twice under CACHE_STATS_EN.
- The FSM, word counter and line buffer live in the top module.

Test Plan:
- Load hit: cpu_req=1, cpu_we=0, cache_hit=1, cache_rdata=0xDEADBEEF -> cpu_stall=0 in the same cycle, cpu_rdata=0xDEADBEEF, mem_req stays 0.
- Load miss at 0x00000034, memory with 2-cycle rvalid latency returning 0x30..0x3C -> mem_addr sequence 0x30, 0x34, 0x38, 0x3C, one outstanding at a time. Then one cache_fill pulse with cache_addr=0x30 and cache_line={0x3C,0x38,0x34,0x30}. cpu_stall is low in the cycle after fill once cache_hit=1.
- mem_gnt held low for 5 cycles in REFILL_REQ -> mem_req and mem_addr are stable for all 5 cycles and no word is captured.
- Store hit to 0x104, data 0x55, cpu_byte=1 -> cache_inv pulses with cache_addr=0x104. mem_req=1, mem_we=1, mem_byte=1, mem_wdata=0x55 until gnt; cpu_stall drops in the gnt cycle.
- rst_n asserted after 2 of 4 refill words -> outputs go to 0 immediately, no cache_fill is issued, and a subsequent miss starts again at word 0.
- CACHE_STATS_EN defined: 3 hits then 1 miss -> hit_count=4 (3 hits plus the post-fill re-lookup) and miss_count=1. Force the counter to 0xFFFFFFFF, then hit -> it stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache miss/refill controller.
package cache_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int OFFSET_BITS = $clog2(DEF_WORDS_PER_LINE) + 2;
  localparam int LINE_BITS   = DEF_WORDS_PER_LINE * DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REFILL_REQ  = 3'd1,
    ST_REFILL_WAIT = 3'd2,
    ST_FILL        = 3'd3,
    ST_STORE       = 3'd4
  } ctrl_state_t;

  // Clears the byte-offset bits so the result points at word 0 of the line.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_bits);
    return addr & ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_stats_ctr.sv
// Saturating event counter; increments once per cycle with inc high and sticks at all-ones.
module cache_stats_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller for a direct-mapped write-through data cache.
// Optional load hit/miss statistics are built when CACHE_STATS_EN is defined.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cpu_req,
  input  logic                               cpu_we,
  input  logic [ADDR_WIDTH-1:0]              cpu_addr,
  input  logic [DATA_WIDTH-1:0]              cpu_wdata,
  input  logic                               cpu_byte,
  output logic                               cpu_stall,
  output logic [DATA_WIDTH-1:0]              cpu_rdata,
  input  logic                               cache_hit,
  input  logic [DATA_WIDTH-1:0]              cache_rdata,
  output logic [ADDR_WIDTH-1:0]              cache_addr,
  output logic                               cache_fill,
  output logic                               cache_inv,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] cache_line,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic                               mem_byte,
  input  logic                               mem_gnt,
  input  logic                               mem_rvalid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic [31:0]                        hit_count,
  output logic [31:0]                        miss_count
);

  localparam int OFF_B = $clog2(WORDS_PER_LINE) + 2;
  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

  ctrl_state_t           state;
  ctrl_state_t           state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_byte;
  logic [DATA_WIDTH-1:0] line_words [WORDS_PER_LINE];

  logic idle;
  logic load_hit;
  logic load_miss;
  logic store_req;

  assign idle      = (state == ST_IDLE);
  assign load_hit  = cpu_req & ~cpu_we & cache_hit;
  assign load_miss = cpu_req & ~cpu_we & ~cache_hit;
  assign store_req = cpu_req & cpu_we;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load_miss) begin
          state_nxt = ST_REFILL_REQ;
        end else if (store_req) begin
          state_nxt = ST_STORE;
        end
      end
      ST_REFILL_REQ:  if (mem_gnt) state_nxt = ST_REFILL_WAIT;
      ST_REFILL_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = (cnt == CNT_LAST) ? ST_FILL : ST_REFILL_REQ;
        end
      end
      ST_FILL:        state_nxt = ST_IDLE;
      ST_STORE:       if (mem_gnt) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // The word counter wraps naturally after the last word, so it is back at 0 by FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      base_addr <= '0;
      st_addr   <= '0;
      st_data   <= '0;
      st_byte   <= 1'b0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        line_words[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (idle && load_miss) begin
        base_addr <= ADDR_WIDTH'(line_base(64'(cpu_addr), OFF_B));
        cnt       <= '0;
      end
      if (idle && !load_miss && store_req) begin
        st_addr <= cpu_addr;
        st_data <= cpu_wdata;
        st_byte <= cpu_byte;
      end
      if ((state == ST_REFILL_WAIT) && mem_rvalid) begin
        line_words[cnt] <= mem_rdata;
        cnt             <= cnt + 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out mid-refill.
  always_comb begin
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    cache_addr = '0;
    cache_fill = 1'b0;
    cache_inv  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byte   = 1'b0;
    if (rst_n) begin
      cpu_rdata = cache_rdata;
      case (state)
        ST_IDLE: begin
          cache_addr = cpu_addr;
          cpu_stall  = load_miss | store_req;
          cache_inv  = store_req & cache_hit;
        end
        ST_REFILL_REQ: begin
          cpu_stall  = 1'b1;
          cache_addr = base_addr;
          mem_req    = 1'b1;
          mem_addr   = base_addr | (ADDR_WIDTH'(cnt) << 2);
        end
        ST_REFILL_WAIT: begin
          cpu_stall  = 1'b1;
          cache_addr = base_addr;
        end
        ST_FILL: begin
          cpu_stall  = 1'b1;
          cache_addr = base_addr;
          cache_fill = 1'b1;
        end
        ST_STORE: begin
          cpu_stall  = ~mem_gnt;
          cache_addr = st_addr;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = st_addr;
          mem_wdata  = st_data;
          mem_byte   = st_byte;
        end
        default: cpu_stall = 1'b1;
      endcase
    end
  end

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_line
    assign cache_line[g*DATA_WIDTH +: DATA_WIDTH] = line_words[g];
  end

`ifdef CACHE_STATS_EN
  logic hit_evt;
  logic miss_evt;

  assign hit_evt  = idle & load_hit;
  assign miss_evt = idle & load_miss;

  cache_stats_ctr #(.WIDTH(32)) u_hit_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_evt),
    .count (hit_count)
  );

  cache_stats_ctr #(.WIDTH(32)) u_miss_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_evt),
    .count (miss_count)
  );
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a simple memory model, expected traffic queued at stimulus time.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we, cpu_byte;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_stall;
  logic [31:0]  cpu_rdata;
  logic         cache_hit;
  logic [31:0]  cache_rdata;
  logic [31:0]  cache_addr;
  logic         cache_fill, cache_inv;
  logic [127:0] cache_line;
  logic         mem_req, mem_we, mem_byte;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_gnt, mem_rvalid;
  logic [31:0]  mem_rdata;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_byte    (cpu_byte),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .cache_addr  (cache_addr),
    .cache_fill  (cache_fill),
    .cache_inv   (cache_inv),
    .cache_line  (cache_line),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byte    (mem_byte),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Expected memory traffic and line fills.
  logic [31:0]  q_rd_addr[$];
  logic [127:0] q_line[$];
  logic [31:0]  q_fill_addr[$];
  logic [31:0]  q_wr_addr[$];
  logic [31:0]  q_wr_data[$];
  logic         q_wr_byte[$];

  // Memory model: grant after gnt_delay waiting cycles, read data (= address) two cycles after the grant.
  int          gnt_delay = 0;
  int          gnt_wait  = 0;
  int          rv_cnt    = 0;
  logic [31:0] rv_data;
  logic        acc_rd;
  logic [31:0] acc_addr;

  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      acc_rd   = mem_req & mem_gnt & ~mem_we;
      acc_addr = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        rv_cnt   = 0;
        gnt_wait = 0;
        mem_gnt  = 1'b0;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
          end
        end
        if (acc_rd) begin
          rv_cnt  = 1;
          rv_data = acc_addr;
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
          if (gnt_wait >= gnt_delay) begin
            mem_gnt  = 1'b1;
            gnt_wait = 0;
          end else begin
            gnt_wait++;
          end
        end else begin
          gnt_wait = 0;
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT produces traffic and checks request stability.
  bit           pend = 1'b0;
  logic [31:0]  p_addr, p_wdata;
  logic         p_we;
  logic [127:0] p_line;
  int           reads_out = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend      = 1'b0;
        reads_out = 0;
      end else begin
        if (pend) begin
          chk("req_held", mem_req, 1'b1);
          chk("addr_held", mem_addr, p_addr);
          chk("we_held", mem_we, p_we);
          chk("wdata_held", mem_wdata, p_wdata);
          if (!p_we) chk("no_capture_while_waiting", cache_line, p_line);
        end
        if (mem_rvalid) reads_out--;
        if (mem_req && !mem_we) chk("one_outstanding", reads_out, 0);
        if (mem_req && mem_gnt) begin
          if (!mem_we) begin
            if (q_rd_addr.size() == 0) chk("rd_unexpected", mem_addr, 32'hFFFF_FFFF);
            else chk("rd_addr", mem_addr, q_rd_addr.pop_front());
            reads_out++;
          end else begin
            if (q_wr_addr.size() == 0) begin
              chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
            end else begin
              chk("wr_addr", mem_addr, q_wr_addr.pop_front());
              chk("wr_data", mem_wdata, q_wr_data.pop_front());
              chk("wr_byte", mem_byte, q_wr_byte.pop_front());
            end
            chk("st_stall_drop", cpu_stall, 1'b0);
          end
        end
        if (cache_fill) begin
          if (q_fill_addr.size() == 0) begin
            chk("fill_unexpected", cache_fill, 1'b0);
          end else begin
            chk("fill_addr", cache_addr, q_fill_addr.pop_front());
            chk("fill_line", cache_line, q_line.pop_front());
          end
        end
        pend    = mem_req & ~mem_gnt;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_we    = mem_we;
        p_line  = cache_line;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    tick();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_byte  = 1'b0;
    cache_hit = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
    tick();
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_addr    = addr;
    cache_hit   = 1'b1;
    cache_rdata = data;
    @(negedge clk);
    chk("hit_stall", cpu_stall, 1'b0);
    chk("hit_rdata", cpu_rdata, data);
    chk("hit_mem_req", mem_req, 1'b0);
    chk("hit_cache_addr", cache_addr, addr);
  endtask

  task automatic do_miss(input logic [31:0] addr, input int gd);
    logic [31:0]  base;
    logic [127:0] line;
    int           k;
    int           w;
    base = addr & ~32'hF;
    gnt_delay = gd;
    for (int i = 0; i < 4; i++) begin
      q_rd_addr.push_back(base + 32'(4 * i));
      line[i*32 +: 32] = base + 32'(4 * i);
    end
    q_line.push_back(line);
    q_fill_addr.push_back(base);
    tick();
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_addr    = addr;
    cache_hit   = 1'b0;
    cache_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("miss_stall", cpu_stall, 1'b1);
    k = 0;
    while (!cache_fill && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("fill_timeout", cache_fill, 1'b1);
    chk("fill_stall", cpu_stall, 1'b1);
    w = int'(addr[3:2]);
    tick();
    cache_hit   = 1'b1;
    cache_rdata = line[w*32 +: 32];
    @(negedge clk);
    chk("post_fill_stall", cpu_stall, 1'b0);
    chk("post_fill_rdata", cpu_rdata, line[w*32 +: 32]);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic bsel, input logic hit, input int gd);
    int k;
    gnt_delay = gd;
    q_wr_addr.push_back(addr);
    q_wr_data.push_back(data);
    q_wr_byte.push_back(bsel);
    tick();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_byte  = bsel;
    cache_hit = hit;
    @(negedge clk);
    chk("st_inv", cache_inv, hit);
    chk("st_inv_addr", cache_addr, addr);
    chk("st_stall", cpu_stall, 1'b1);
    tick();
    cache_hit = 1'b0;
    @(negedge clk);
    chk("st_inv_once", cache_inv, 1'b0);
    chk("st_mem_we", mem_we, 1'b1);
    k = 0;
    while (cpu_stall && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("store_timeout", cpu_stall, 1'b0);
    idle_cpu();
  endtask

  task automatic do_reset_mid_refill();
    int k;
    int nrv;
    gnt_delay = 0;
    q_rd_addr.push_back(32'h80);
    q_rd_addr.push_back(32'h84);
    tick();
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h88;
    cache_hit = 1'b0;
    k   = 0;
    nrv = 0;
    while (nrv < 2 && k < 100) begin
      @(negedge clk);
      if (mem_rvalid) nrv++;
      k++;
    end
    if (k >= 100) chk("rst_rvalid_timeout", nrv, 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", cpu_stall, 1'b0);
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_fill", cache_fill, 1'b0);
    chk("rst_mid_cache_addr", cache_addr, 32'h0);
    chk("rst_mid_line", cache_line, 128'h0);
    cpu_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rd_drained", q_rd_addr.size(), 0);
    do_miss(32'h88, 1);
    idle_cpu();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_addr    = 32'h40;
    cpu_wdata   = 32'h0;
    cpu_byte    = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = 32'h1234_5678;
    #12;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ctrl", {mem_req, mem_we, mem_byte, cache_fill, cache_inv}, 5'b0);
    chk("rst_addrs", {mem_addr, cache_addr, mem_wdata}, 96'h0);
    chk("rst_line", cache_line, 128'h0);
    chk("rst_counts", {hit_count, miss_count}, 64'h0);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;

    do_hit(32'h10, 32'hDEAD_BEEF);
    do_hit(32'h24, 32'h0BAD_F00D);
    do_hit(32'h38, 32'hA5A5_5A5A);
    idle_cpu();

    do_miss(32'h34, 0);
    idle_cpu();

    do_miss(32'h200, 5);
    idle_cpu();

    do_store(32'h104, 32'h55, 1'b1, 1'b1, 3);
    do_store(32'h208, 32'hA5A5_A5A5, 1'b0, 1'b0, 0);

    do_reset_mid_refill();

`ifdef CACHE_STATS_EN
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_hit(32'h04, 32'h1);
    do_hit(32'h08, 32'h2);
    do_hit(32'h0C, 32'h3);
    idle_cpu();
    do_miss(32'h300, 0);
    idle_cpu();
    @(negedge clk);
    chk("stat_hits", hit_count, 32'd4);
    chk("stat_misses", miss_count, 32'd1);
    force dut.u_hit_ctr.count = 32'hFFFF_FFFF;
    tick();
    release dut.u_hit_ctr.count;
    do_hit(32'h14, 32'h5);
    idle_cpu();
    @(negedge clk);
    chk("stat_saturate", hit_count, 32'hFFFF_FFFF);
`endif

    tick();
    tick();
    chk("rd_queue_empty", q_rd_addr.size(), 0);
    chk("fill_queue_empty", q_fill_addr.size(), 0);
    chk("wr_queue_empty", q_wr_addr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
